// File: rtl/mb_pkg.sv
// Shared encodings for the memory-bus pattern checker: test modes and FSM states.
package mb_pkg;

  typedef enum logic [1:0] {
    MODE_AGG  = 2'd0,
    MODE_LANE = 2'd1,
    MODE_ID   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mb_lane_err_cnt.sv
// One data lane: XOR compare, saturating bit-error counter and consecutive-match run counter.
module mb_lane_err_cnt #(
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 16,
  parameter int MATCH_RUN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             beat,
  input  logic [WIDTH-1:0] rx_word,
  input  logic [WIDTH-1:0] ref_word,
  output logic [WIDTH-1:0] diff,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             pass_nxt
);

  localparam int INC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam int RUN_W = $clog2(MATCH_RUN + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(MATCH_RUN);

  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             pass;
  logic [INC_W-1:0] inc;
  logic [SUM_W-1:0] sum;

  // Next-state values are exported so the top can latch results including the stop-cycle beat.
  always_comb begin
    diff = rx_word ^ ref_word;
    inc  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      inc = inc + INC_W'(diff[i]);
    end
    sum      = SUM_W'(cnt) + SUM_W'(inc);
    cnt_nxt  = cnt;
    run_nxt  = run;
    pass_nxt = pass;
    if (beat) begin
      cnt_nxt = (sum > CNT_MAX) ? '1 : CNT_W'(sum);
      if (diff == '0) begin
        run_nxt = (run == RUN_TGT) ? run : run + 1'b1;
        if (run_nxt == RUN_TGT) begin
          pass_nxt = 1'b1;
        end
      end else begin
        run_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      run  <= '0;
      pass <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      run  <= '0;
      pass <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      run  <= run_nxt;
      pass <= pass_nxt;
    end
  end

endmodule

// File: rtl/mb_pattern_checker.sv
// Multi-lane pattern checker: aggregate, per-lane and ID-match test modes with
// saturating error counters; results latched when the test is stopped.
module mb_pattern_checker
  import mb_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int WIDTH     = 32,
  parameter int CNT_W     = 16,
  parameter int MATCH_RUN = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [1:0]                 i_mode,
  input  logic                       i_valid,
  input  logic [NUM_LANES*WIDTH-1:0] i_rx_data,
  input  logic [NUM_LANES*WIDTH-1:0] i_ref_data,
  input  logic [NUM_LANES-1:0]       i_lane_mask,
  input  logic [CNT_W-1:0]           i_lane_thresh,
  input  logic [CNT_W-1:0]           i_agg_thresh,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [NUM_LANES-1:0]       o_lane_pass,
  output logic                       o_agg_pass,
  output logic [CNT_W-1:0]           o_agg_err_cnt
);

  localparam int INC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  state_e state;
  mode_e  mode;
  logic   beat;

  logic [WIDTH-1:0]     lane_diff    [NUM_LANES];
  logic [CNT_W-1:0]     lane_cnt_nxt [NUM_LANES];
  logic [NUM_LANES-1:0] id_pass_nxt;

  logic [WIDTH-1:0]     agg_diff;
  logic [INC_W-1:0]     agg_inc;
  logic [SUM_W-1:0]     agg_sum;
  logic [CNT_W-1:0]     agg_cnt;
  logic [CNT_W-1:0]     agg_cnt_nxt;
  logic [NUM_LANES-1:0] lane_pass_nxt;
  logic                 agg_pass_nxt;
  logic                 agg_mode;

  assign beat     = (state == ST_RUN) && i_valid && !i_start;
  assign agg_mode = (mode == MODE_AGG) || (mode == MODE_RSVD);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    mb_lane_err_cnt #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .MATCH_RUN (MATCH_RUN)
    ) u_lane (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clear    (i_start),
      .beat     (beat && i_lane_mask[k]),
      .rx_word  (i_rx_data[k*WIDTH +: WIDTH]),
      .ref_word (i_ref_data[k*WIDTH +: WIDTH]),
      .diff     (lane_diff[k]),
      .cnt_nxt  (lane_cnt_nxt[k]),
      .pass_nxt (id_pass_nxt[k])
    );
  end

  always_comb begin
    agg_diff = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (i_lane_mask[k]) begin
        agg_diff = agg_diff | lane_diff[k];
      end
    end
    agg_inc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      agg_inc = agg_inc + INC_W'(agg_diff[i]);
    end
    agg_sum     = SUM_W'(agg_cnt) + SUM_W'(agg_inc);
    agg_cnt_nxt = agg_cnt;
    if (beat) begin
      agg_cnt_nxt = (agg_sum > CNT_MAX) ? '1 : CNT_W'(agg_sum);
    end

    lane_pass_nxt = '1;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (i_lane_mask[k]) begin
        case (mode)
          MODE_LANE: lane_pass_nxt[k] = (lane_cnt_nxt[k] <= i_lane_thresh);
          MODE_ID:   lane_pass_nxt[k] = id_pass_nxt[k];
          default:   lane_pass_nxt[k] = 1'b1;
        endcase
      end
    end

    case (mode)
      MODE_AGG:  agg_pass_nxt = (agg_cnt_nxt <= i_agg_thresh);
      MODE_RSVD: agg_pass_nxt = 1'b0;
      default:   agg_pass_nxt = &lane_pass_nxt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      agg_cnt <= '0;
    end else if (i_start) begin
      agg_cnt <= '0;
    end else begin
      agg_cnt <= agg_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      mode          <= MODE_AGG;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_lane_pass   <= '0;
      o_agg_pass    <= 1'b0;
      o_agg_err_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        state         <= ST_RUN;
        mode          <= mode_e'(i_mode);
        o_busy        <= 1'b1;
        o_lane_pass   <= '0;
        o_agg_pass    <= 1'b0;
        o_agg_err_cnt <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (i_stop) begin
              state         <= ST_DONE;
              o_busy        <= 1'b0;
              o_done        <= 1'b1;
              o_lane_pass   <= lane_pass_nxt;
              o_agg_pass    <= agg_pass_nxt;
              o_agg_err_cnt <= agg_mode ? agg_cnt_nxt : '0;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mb_pattern_checker.sv
// Directed self-checking bench for mb_pattern_checker, with a narrow CNT_W=4 instance for saturation.
module tb_mb_pattern_checker;

  localparam int NL = 16;
  localparam int W  = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            valid = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [NL*W-1:0] rx = '0;
  logic [NL*W-1:0] refd = '0;
  logic [NL-1:0]   mask = '1;
  logic [CW-1:0]   lthr = '0;
  logic [CW-1:0]   athr = '0;
  logic            busy, done, agg_pass;
  logic [NL-1:0]   lane_pass;
  logic [CW-1:0]   agg_cnt;

  logic [15:0] s_rx = '0;
  logic [15:0] s_ref = '0;
  logic [1:0]  s_mask = '1;
  logic [3:0]  s_lthr = '0;
  logic [3:0]  s_athr = '0;
  logic        s_busy, s_done, s_agg_pass;
  logic [1:0]  s_lane_pass;
  logic [3:0]  s_agg_cnt;

  int checks = 0;
  int errors = 0;

  mb_pattern_checker #(.NUM_LANES(NL), .WIDTH(W), .CNT_W(CW), .MATCH_RUN(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_valid(valid), .i_rx_data(rx), .i_ref_data(refd), .i_lane_mask(mask),
    .i_lane_thresh(lthr), .i_agg_thresh(athr), .o_busy(busy), .o_done(done),
    .o_lane_pass(lane_pass), .o_agg_pass(agg_pass), .o_agg_err_cnt(agg_cnt)
  );

  mb_pattern_checker #(.NUM_LANES(2), .WIDTH(8), .CNT_W(4), .MATCH_RUN(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_valid(valid), .i_rx_data(s_rx), .i_ref_data(s_ref), .i_lane_mask(s_mask),
    .i_lane_thresh(s_lthr), .i_agg_thresh(s_athr), .o_busy(s_busy), .o_done(s_done),
    .o_lane_pass(s_lane_pass), .o_agg_pass(s_agg_pass), .o_agg_err_cnt(s_agg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [NL*W-1:0] r, input logic [NL*W-1:0] x, input logic stp);
    refd  = r;
    rx    = x;
    valid = 1'b1;
    stop  = stp;
    tick();
    valid = 1'b0;
    stop  = 1'b0;
    refd  = '0;
    rx    = '0;
  endtask

  task automatic expect_done(input string tag);
    int n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  function automatic logic [NL*W-1:0] pat(input int b);
    logic [W-1:0] w;
    w   = W'(32'h1357_9BDF * (b + 1));
    pat = {NL{w}};
  endfunction

  function automatic logic [NL*W-1:0] flip(input logic [NL*W-1:0] v, input int k,
                                           input logic [W-1:0] bits);
    flip = v;
    flip[k*W +: W] = v[k*W +: W] ^ bits;
  endfunction

  initial begin
    logic [NL*W-1:0] r;
    logic [NL*W-1:0] x;
    int dn;

    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lane_pass", 32'(lane_pass), 32'h0);
    check("rst_agg_pass", 32'(agg_pass), 32'd0);
    check("rst_agg_cnt", 32'(agg_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("idle_stop_busy", 32'(busy), 32'd0);
    check("idle_stop_done", 32'(done), 32'd0);

    // LANE: lane 3 gets 2 bad bits per beat for 10 beats, last beat rides the stop cycle
    lthr = 16'd15;
    pulse_start(2'd1);
    check("lane_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 10; b++) begin
      r = pat(b);
      beat(r, flip(r, 3, 32'h0000_0081), b == 9);
    end
    expect_done("lane_done");
    check("lane_pass", 32'(lane_pass), 32'h0000_FFF7);
    check("lane_agg_pass", 32'(agg_pass), 32'd0);
    check("lane_agg_cnt", 32'(agg_cnt), 32'd0);
    check("lane_busy_off", 32'(busy), 32'd0);
    tick();
    check("lane_done_pulse", 32'(done), 32'd0);
    check("lane_pass_stable", 32'(lane_pass), 32'h0000_FFF7);

    // AGG: same bit on lanes 0 and 5 counts once per beat; stop-cycle beat included
    athr = 16'd4;
    pulse_start(2'd0);
    for (int b = 0; b < 4; b++) begin
      r = pat(b);
      beat(r, flip(flip(r, 0, 32'h200), 5, 32'h200), b == 3);
    end
    expect_done("agg_done");
    check("agg_cnt", 32'(agg_cnt), 32'd4);
    check("agg_pass", 32'(agg_pass), 32'd1);
    check("agg_lane_pass", 32'(lane_pass), 32'h0000_FFFF);

    // Reserved mode behaves as AGG but never passes
    athr = 16'd100;
    pulse_start(2'd3);
    for (int b = 0; b < 4; b++) begin
      r = pat(b);
      beat(r, flip(flip(r, 0, 32'h200), 5, 32'h200), b == 3);
    end
    expect_done("rsvd_done");
    check("rsvd_cnt", 32'(agg_cnt), 32'd4);
    check("rsvd_agg_pass", 32'(agg_pass), 32'd0);

    // Lane 4 masked with every bit wrong
    mask = 16'hFFEF;
    lthr = 16'd0;
    athr = 16'd0;
    pulse_start(2'd1);
    for (int b = 0; b < 3; b++) begin
      r = pat(b);
      beat(r, flip(r, 4, 32'hFFFF_FFFF), b == 2);
    end
    expect_done("mask_lane_done");
    check("mask_lane_pass", 32'(lane_pass), 32'h0000_FFFF);
    check("mask_lane_agg_pass", 32'(agg_pass), 32'd1);
    pulse_start(2'd0);
    for (int b = 0; b < 3; b++) begin
      r = pat(b);
      beat(r, flip(r, 4, 32'hFFFF_FFFF), b == 2);
    end
    expect_done("mask_agg_done");
    check("mask_agg_cnt", 32'(agg_cnt), 32'd0);
    check("mask_agg_pass", 32'(agg_pass), 32'd1);
    mask = '1;

    // ID: lane 2 = 15 hits, 1 miss, 16 hits; lane 7 = 15 hits then misses
    pulse_start(2'd2);
    for (int b = 0; b < 32; b++) begin
      r = pat(b);
      x = r;
      if (b == 15) x = flip(x, 2, 32'h1);
      if (b >= 15) x = flip(x, 7, 32'h8000_0000);
      beat(r, x, b == 31);
    end
    expect_done("id_done");
    check("id_lane_pass", 32'(lane_pass), 32'h0000_FF7F);
    check("id_agg_pass", 32'(agg_pass), 32'd0);
    check("id_agg_cnt", 32'(agg_cnt), 32'd0);

    // start+stop together restarts with cleared counters
    lthr = 16'd0;
    pulse_start(2'd1);
    r = pat(3);
    beat(r, flip(r, 0, 32'h1F), 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    mode  = 2'd1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_no_done", 32'(done), 32'd0);
    beat(r, r, 1'b1);
    expect_done("restart_done");
    check("restart_lane_pass", 32'(lane_pass), 32'h0000_FFFF);
    check("restart_agg_pass", 32'(agg_pass), 32'd1);

    // Reset mid-run aborts without a done pulse
    pulse_start(2'd1);
    beat(r, flip(r, 1, 32'h3), 1'b0);
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_lane_pass", 32'(lane_pass), 32'h0);
    rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      tick();
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Saturation on CNT_W=4: 5 beats x 4 bad bits = 20 -> 15
    s_athr = 4'd15;
    pulse_start(2'd0);
    for (int b = 0; b < 5; b++) begin
      s_ref = 16'h3CC3;
      s_rx  = 16'h3CCC;
      beat('0, '0, b == 4);
    end
    s_ref = '0;
    s_rx  = '0;
    tick();
    check("sat_done_seen", 32'(s_lane_pass), 32'h3);
    check("sat_agg_cnt", 32'(s_agg_cnt), 32'd15);
    check("sat_agg_pass", 32'(s_agg_pass), 32'd1);
    s_lthr = 4'd14;
    pulse_start(2'd1);
    for (int b = 0; b < 5; b++) begin
      s_ref = 16'h3CC3;
      s_rx  = 16'h3CCC;
      beat('0, '0, b == 4);
    end
    s_ref = '0;
    s_rx  = '0;
    check("sat_lane_done", 32'(s_done), 32'd1);
    check("sat_lane_pass", 32'(s_lane_pass), 32'h2);
    check("sat_lane_cnt_zero", 32'(s_agg_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_pattern_checker.md
MB_PATTERN_CHECKER -- requirements
Module: mb_pattern_checker

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16, number of data lanes compared.
REQ-002 SHALL have parameter WIDTH, default 32, bits per lane per beat.
REQ-003 SHALL have parameter CNT_W, default 16, width of every error counter.
REQ-004 SHALL have parameter MATCH_RUN, default 16, consecutive full-word matches for ID-mode pass.
REQ-005 SHALL have ports `i_clk`  in  1  clock; `i_rst_n`  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port `i_start`  in  1  single-cycle pulse that clears all state and begins a test.
REQ-007 SHALL have port `i_stop`  in  1  single-cycle pulse that ends the test.
REQ-008 SHALL have port `i_mode`  in  2  test mode, sampled on i_start: 0 AGG, 1 LANE, 2 ID, 3 reserved.
REQ-009 SHALL have port `i_valid`  in  1  data beat qualifier.
REQ-010 SHALL have ports `i_rx_data`, `i_ref_data`  in  NUM_LANES*WIDTH  received/reference words, lane k at [k*WIDTH +: WIDTH].
REQ-011 SHALL have port `i_lane_mask`  in  NUM_LANES  1 = lane participates.
REQ-012 SHALL have ports `i_lane_thresh`  in  CNT_W  per-lane limit; `i_agg_thresh`  in  CNT_W  aggregate limit.
REQ-013 SHALL have ports `o_busy`  out  1  test running; `o_done`  out  1  single-cycle pulse, results valid.
REQ-014 SHALL have ports `o_lane_pass`  out  NUM_LANES  per-lane result; `o_agg_pass`  out  1  aggregate result; `o_agg_err_cnt`  out  CNT_W  aggregate count.

Function
REQ-015 SHALL implement FSM IDLE->RUN on i_start; RUN->DONE on i_stop; DONE->IDLE after one cycle with o_done=1.
REQ-016 SHALL, on i_start in any state, clear all counters and restart RUN; i_start wins over a simultaneous i_stop.
REQ-017 SHALL ignore i_stop outside RUN and ignore i_valid outside RUN.
REQ-018 SHALL count beats only when RUN and i_valid=1; masked lanes contribute zero mismatches.
REQ-019 AGG: per beat, add popcount over WIDTH of OR-across-unmasked-lanes of (rx XOR ref) to the aggregate counter.
REQ-020 LANE: per beat, add popcount of (rx XOR ref) to that lane's counter.
REQ-021 ID: per lane, run counter +1 on full-word match, reset to 0 on mismatch; lane passes sticky once run reaches MATCH_RUN.
REQ-022 All counters SHALL saturate at 2^CNT_W-1, never wrap; per-beat increment SHALL be computed at full width before saturation.
REQ-023 Results SHALL be registered on the RUN->DONE transition, including a beat valid in the i_stop cycle; stable until next i_start.
REQ-024 o_lane_pass[k] SHALL be 1 for masked lanes; LANE: count<=i_lane_thresh; ID: sticky pass; AGG: all 1.
REQ-025 o_agg_pass SHALL be count<=i_agg_thresh in AGG; in LANE/ID SHALL equal AND of o_lane_pass.
REQ-026 o_agg_err_cnt SHALL report the aggregate counter in AGG and 0 otherwise.
REQ-027 Mode 3 SHALL behave as AGG with o_agg_pass forced 0.
REQ-028 o_busy SHALL be 1 exactly while in RUN.

Reset
REQ-029 On i_rst_n low: FSM IDLE, all counters 0, o_busy=0, o_done=0, o_lane_pass all 0, o_agg_pass=0, o_agg_err_cnt=0.
REQ-030 Reset asserted mid-RUN SHALL abort the test with no o_done pulse.

Structure
REQ-031 Mode encodings and FSM state encodings SHALL live in shared package mb_pkg.
REQ-032 One sub-module SHALL be used: mb_lane_err_cnt, per-lane XOR/popcount, saturating counter, and run counter, instantiated NUM_LANES times.

Verification
REQ-033 LANE, 10 beats, lane 3 has 2 flipped bits per beat, thresh 15 -> o_lane_pass[3]=0, others 1, o_agg_pass=0.
REQ-034 AGG, same bit flipped on lanes 0 and 5 for 4 beats, thresh 4 -> o_agg_err_cnt=4, o_agg_pass=1.
REQ-035 ID, lane 2: 15 matches, 1 miss, 16 matches -> o_lane_pass[2]=1; lane 7: 15 matches only -> 0.
REQ-036 LANE, CNT_W=4, 20 errored bits -> count saturates at 15, no wrap.
REQ-037 i_start and i_stop in the same cycle -> restart in RUN, no o_done; reset mid-RUN -> IDLE, no o_done.
REQ-038 Lane 4 masked with all bits wrong -> o_lane_pass[4]=1, no aggregate contribution.
